// File: rtl/v810_prefetch.sv
// v810_prefetch: instruction prefetch queue feeding v810_exec.
// Fetches 32-bit words and buffers them as halfwords. It presents the head
// halfword pair and its PC to the decoder, and flushes and restarts on
// branch redirects.
// Optional build macro: V810_PREFETCH_BYPASS_EN. When it is defined, a fetch
// that lands in an empty queue drives the head outputs in the same cycle.
module v810_prefetch #(
    parameter int unsigned DEPTH    = 8,
    parameter logic [31:0] RESET_PC = 32'hFFFF_FFF0
) (
    input  logic        CLK,
    input  logic        RES,
    input  logic        CE,
    output logic [31:0] IA,
    output logic        IMRQn,
    input  logic        READYn,
    input  logic [31:0] ID,
    input  logic        JMP,
    input  logic [31:0] JMP_PC,
    output logic [15:0] HW0,
    output logic [15:0] HW1,
    output logic [31:0] PC,
    output logic        VALID1,
    output logic        VALID2,
    input  logic [1:0]  CONSUME
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef enum logic [1:0] {ST_RESET, ST_FETCH, ST_FULL} state_t;

    state_t         r_state;
    logic           r_imrqn;
    logic [31:0]    r_ia;
    logic [31:0]    r_pc;
    logic           r_skip;
    logic [15:0]    r_mem [DEPTH];
    logic [PW-1:0]  r_rd;
    logic [PW-1:0]  r_wr;
    logic [CW-1:0]  r_count;
    logic [15:0]    r_hw0;
    logic [15:0]    r_hw1;
    logic           r_v1;
    logic           r_v2;

    logic           w_comp;
    logic           w_pending;
    logic [1:0]     w_push_n;
    logic [1:0]     w_pop;
    logic [15:0]    w_push0;
    logic [15:0]    w_push1;
    logic [CW-1:0]  w_count_next;
    logic           w_req_next;
    logic [CW-1:0]  w_k [2];
    logic [CW-1:0]  w_d [2];
    logic [15:0]    w_elem [2];
    logic           w_unused;

    // Address bit 0 of a redirect target carries no information.
    assign w_unused = JMP_PC[0];

    // Fetch completion, pop/push amounts, request decision and new head pair.
    always_comb begin
        w_comp       = CE & ~JMP & ~r_imrqn & ~READYn;
        w_pending    = (r_state == ST_FETCH) & READYn;
        w_push_n     = w_comp ? (r_skip ? 2'd1 : 2'd2) : 2'd0;
        w_pop        = (CE & ~JMP) ? CONSUME : 2'd0;
        w_push0      = r_skip ? ID[31:16] : ID[15:0];
        w_push1      = ID[31:16];
        w_count_next = r_count + CW'(w_push_n) - CW'(w_pop);
        if (JMP || w_pending) begin
            w_req_next = 1'b1;
        end else begin
            w_req_next = (w_count_next <= CW'(DEPTH - 2));
        end
        // The new head is element pop/pop+1 of (queued data ++ pushed data).
        for (int j = 0; j < 2; j++) begin
            w_k[j] = CW'(w_pop) + CW'(j);
            w_d[j] = w_k[j] - r_count;
            if (w_k[j] < r_count) begin
                w_elem[j] = r_mem[r_rd + PW'(w_k[j])];
            end else if (w_d[j] == '0) begin
                w_elem[j] = w_push0;
            end else begin
                w_elem[j] = w_push1;
            end
        end
    end

    // Halfword storage; slots are only read below the count, so no reset is needed.
    always_ff @(posedge CLK) begin
        if (w_comp) begin
            r_mem[r_wr] <= w_push0;
            if (!r_skip) begin
                r_mem[r_wr + PW'(1)] <= w_push1;
            end
        end
    end

    // Request FSM, pointers, PC/IA tracking and registered head outputs.
    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            r_state <= ST_RESET;
            r_imrqn <= 1'b1;
            r_ia    <= {RESET_PC[31:2], 2'b00};
            r_pc    <= RESET_PC;
            r_skip  <= RESET_PC[1];
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
            r_hw0   <= '0;
            r_hw1   <= '0;
            r_v1    <= 1'b0;
            r_v2    <= 1'b0;
        end else if (CE) begin
            r_state <= w_req_next ? ST_FETCH : ST_FULL;
            r_imrqn <= ~w_req_next;
            if (JMP) begin
                r_ia    <= {JMP_PC[31:2], 2'b00};
                r_pc    <= {JMP_PC[31:1], 1'b0};
                r_skip  <= JMP_PC[1];
                r_rd    <= '0;
                r_wr    <= '0;
                r_count <= '0;
                r_v1    <= 1'b0;
                r_v2    <= 1'b0;
            end else begin
                r_rd    <= r_rd + PW'(w_pop);
                r_wr    <= r_wr + PW'(w_push_n);
                r_count <= w_count_next;
                r_pc    <= r_pc + {29'd0, w_pop, 1'b0};
                if (w_comp) begin
                    r_ia   <= r_ia + 32'd4;
                    r_skip <= 1'b0;
                end
                r_hw0 <= w_elem[0];
                r_hw1 <= w_elem[1];
                r_v1  <= (w_count_next != '0);
                r_v2  <= (w_count_next >= CW'(2));
            end
        end
    end

    assign IA    = r_ia;
    assign IMRQn = r_imrqn;
    assign PC    = r_pc;

`ifdef V810_PREFETCH_BYPASS_EN
    logic w_byp;

    // A fetch landing in an empty queue is shown to the decoder immediately.
    assign w_byp  = w_comp & (r_count == '0);
    assign HW0    = w_byp ? w_push0 : r_hw0;
    assign HW1    = w_byp ? w_push1 : r_hw1;
    assign VALID1 = w_byp | r_v1;
    assign VALID2 = w_byp ? (w_push_n == 2'd2) : r_v2;
`else
    assign HW0    = r_hw0;
    assign HW1    = r_hw1;
    assign VALID1 = r_v1;
    assign VALID2 = r_v2;
`endif

endmodule
